inv_butterfly_serial: RTL

- Inverse of the scaled sum/difference combiner used in the datapath, which produces p = K·a + K·b and q = K·a − K·b with K ≈ 0.6875.
- This block recovers a = (p+q)·C and b = (p−q)·C, where C = 1/(2K) ≈ 0.7265625, implemented as a shift-add sum.
- Scaling is done serially, one shift term per cycle, to save adders; operands move through valid/ready handshakes on both sides.
- Sits downstream of the combiner in the back-substitution / output path.

---
 rtl/inv_butterfly_serial.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/inv_butterfly_serial.sv
// Inverse sum/difference combiner: a = (p+q)*C, b = (p-q)*C with C ~= 0.7265625,
// applying the five shift-add terms of C serially, one per cycle, behind valid/ready handshakes.
module inv_butterfly_serial #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned FRAC       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] p_in,
  input  logic signed [DATA_WIDTH-1:0] q_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;
  localparam int unsigned ACC_W = DATA_WIDTH + 4;
  localparam int unsigned IDX_W = 3;

  generate
    if (FRAC >= DATA_WIDTH) begin : g_bad_frac
      $error("FRAC must be smaller than DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic signed [SUM_W-1:0]   s_q, s_d;
  logic signed [SUM_W-1:0]   d_q, d_d;
  logic signed [ACC_W-1:0]   acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0]   acc_b_q, acc_b_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] a_q, a_d;
  logic signed [DATA_WIDTH-1:0] b_q, b_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]   sum_a_c;
  logic signed [ACC_W-1:0]   sum_b_c;

  // Shift amounts of C = 2^-1 + 2^-3 + 2^-4 + 2^-5 + 2^-7
  function automatic logic [IDX_W-1:0] shift_of(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    return 3'd1;
      3'd1:    return 3'd3;
      3'd2:    return 3'd4;
      3'd3:    return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  // Arithmetic right shift (floor toward -inf) of a sign-extended operand
  function automatic logic signed [ACC_W-1:0] term(input logic signed [SUM_W-1:0] v,
                                                   input logic [IDX_W-1:0]        sh);
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-SUM_W){v[SUM_W-1]}}, v};
    return ext >>> sh;
  endfunction

  // In range when all bits above the output sign bit agree with it
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
    if ((&v[ACC_W-1:DATA_WIDTH-1]) || !(|v[ACC_W-1:DATA_WIDTH-1]))
      return v[DATA_WIDTH-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      d_q         <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      d_q         <= d_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    d_d         = d_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sum_a_c     = acc_a_q + term(s_q, shift_of(idx_q));
    sum_b_c     = acc_b_q + term(d_q, shift_of(idx_q));

    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid) begin
          s_d        = {p_in[DATA_WIDTH-1], p_in} + {q_in[DATA_WIDTH-1], q_in};
          d_d        = {p_in[DATA_WIDTH-1], p_in} - {q_in[DATA_WIDTH-1], q_in};
          acc_a_d    = '0;
          acc_b_d    = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ACC;
        end
      end
      ACC: begin
        in_ready_d = 1'b0;
        acc_a_d    = sum_a_c;
        acc_b_d    = sum_b_c;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q >= IDX_W'(4)) begin
          a_d         = sat(sum_a_c);
          b_d         = sat(sum_b_c);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;

endmodule
